csr_exec_unit: RTL and testbench

//  Execute stage for SYSTEM-class instructions (CSRRW/S/C, CSRRWI/SI/CI, ECALL, MRET); sits directly upstream of the CSR file.

---
 rtl/csr_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_csr_exec_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_unit.sv
// ---------------------------------------------------------------------------------------------
// csr_exec_unit
//   Execute stage for SYSTEM-class instructions (CSRRW/S/C, CSRRWI/SI/CI, ECALL, MRET).
//   Accepts one decoded instruction per handshake, reads the CSR file combinationally during a
//   single EXEC cycle, issues at most one write strobe, and presents the rd writeback value and
//   next PC to writeback until accepted.
//
// Ports
//   i_clock, i_reset              clock, asynchronous active-low reset
//   i_valid/o_ready               upstream instruction handshake
//   i_pc, i_funct3, i_sys_t,
//   i_csr_addr, i_rs1_idx,
//   i_rs1_data, i_rd              decoded instruction fields
//   o_csr_valid, o_csr_wen,
//   o_csr_t, o_csr, o_csr_pc,
//   o_csr_wdata, o_csr_mcause     CSR file transaction (meaningful only in EXEC)
//   i_csr_rdata, i_csr_upc        combinational CSR read data and trap/return target
//   o_valid/i_ready               writeback handshake
//   o_rd, o_rd_wen, o_rd_data,
//   o_npc, o_redirect             writeback result (held stable while o_valid)
// ---------------------------------------------------------------------------------------------
module csr_exec_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ECALL_CAUSE = 11
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_sys_t,
    input  logic [11:0]     i_csr_addr,
    input  logic [4:0]      i_rs1_idx,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [4:0]      i_rd,
    output logic            o_csr_valid,
    output logic            o_csr_wen,
    output logic [2:0]      o_csr_t,
    output logic [11:0]     o_csr,
    output logic [XLEN-1:0] o_csr_pc,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic [XLEN-1:0] o_csr_mcause,
    input  logic [XLEN-1:0] i_csr_rdata,
    input  logic [XLEN-1:0] i_csr_upc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [4:0]      o_rd,
    output logic            o_rd_wen,
    output logic [XLEN-1:0] o_rd_data,
    output logic [XLEN-1:0] o_npc,
    output logic            o_redirect
);

    typedef enum logic [1:0] {StIdle, StExec, StWait} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_funct3;
    logic [1:0]      r_sys_t;
    logic [11:0]     r_csr_addr;
    logic [4:0]      r_rs1_idx;
    logic [XLEN-1:0] r_rs1_data;
    logic [4:0]      r_rd;
    logic            r_rd_wen;
    logic [XLEN-1:0] r_rd_data;
    logic [XLEN-1:0] r_npc;
    logic            r_redirect;

    logic            w_exec;
    logic            w_is_ecall;
    logic            w_is_mret;
    logic            w_is_csr;
    logic            w_wen;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_pc_plus4;

    // Decode of the latched instruction. funct3=100 and SYSTEM with sys_t=1x fall through as
    // illegal: none of the flags below are set for them.
    assign w_exec     = (r_state == StExec);
    assign w_is_ecall = (r_funct3 == 3'b000) && (r_sys_t == 2'b00);
    assign w_is_mret  = (r_funct3 == 3'b000) && (r_sys_t == 2'b01);
    assign w_is_csr   = (r_funct3[1:0] != 2'b00);

    // Immediate forms use the zero-extended rs1 index as the source operand.
    assign w_src      = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;
    assign w_pc_plus4 = r_pc + XLEN'(4);

    always_comb begin
        w_wdata = '0;
        unique case (r_funct3[1:0])
            2'b01:   w_wdata = w_src;
            2'b10:   w_wdata = i_csr_rdata | w_src;
            2'b11:   w_wdata = i_csr_rdata & ~w_src;
            default: w_wdata = '0;
        endcase
    end

    // Set/clear with a zero source is a pure read and must not disturb side-effecting CSRs.
    assign w_wen = w_is_ecall ||
                   (w_is_csr && ((r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0)));

    // The CSR-side transaction depends on the same-cycle read data, so it is decoded from state
    // rather than registered; everything is forced quiet outside EXEC.
    assign o_ready      = (r_state == StIdle);
    assign o_valid      = (r_state == StWait);
    assign o_csr_valid  = w_exec;
    assign o_csr_wen    = w_exec && w_wen;
    assign o_csr_t      = (w_exec && w_is_ecall) ? 3'b011 :
                          (w_exec && w_is_mret)  ? 3'b000 : 3'b001;
    assign o_csr        = w_exec ? r_csr_addr : '0;
    assign o_csr_pc     = w_exec ? r_pc : '0;
    assign o_csr_wdata  = w_exec ? w_wdata : '0;
    assign o_csr_mcause = (w_exec && w_is_ecall) ? XLEN'(ECALL_CAUSE) : '0;

    assign o_rd         = r_rd;
    assign o_rd_wen     = r_rd_wen;
    assign o_rd_data    = r_rd_data;
    assign o_npc        = r_npc;
    assign o_redirect   = r_redirect;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_pc       <= '0;
            r_funct3   <= '0;
            r_sys_t    <= '0;
            r_csr_addr <= '0;
            r_rs1_idx  <= '0;
            r_rs1_data <= '0;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_rd_data  <= '0;
            r_npc      <= '0;
            r_redirect <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_pc       <= i_pc;
                        r_funct3   <= i_funct3;
                        r_sys_t    <= i_sys_t;
                        r_csr_addr <= i_csr_addr;
                        r_rs1_idx  <= i_rs1_idx;
                        r_rs1_data <= i_rs1_data;
                        r_rd       <= i_rd;
                        r_state    <= StExec;
                    end
                end
                StExec: begin
                    // Trap target is sampled alongside the write, so ECALL sees pre-write mtvec.
                    r_rd_wen   <= w_is_csr && (r_rd != 5'd0);
                    r_rd_data  <= i_csr_rdata;
                    r_npc      <= (w_is_ecall || w_is_mret) ? i_csr_upc : w_pc_plus4;
                    r_redirect <= w_is_ecall || w_is_mret;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (i_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_exec_unit.sv
module tb_csr_exec_unit;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ECALL_CAUSE = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_pc;
    logic [2:0]      i_funct3;
    logic [1:0]      i_sys_t;
    logic [11:0]     i_csr_addr;
    logic [4:0]      i_rs1_idx;
    logic [31:0]     i_rs1_data;
    logic [4:0]      i_rd;
    logic            o_csr_valid;
    logic            o_csr_wen;
    logic [2:0]      o_csr_t;
    logic [11:0]     o_csr;
    logic [31:0]     o_csr_pc;
    logic [31:0]     o_csr_wdata;
    logic [31:0]     o_csr_mcause;
    logic [31:0]     i_csr_rdata;
    logic [31:0]     i_csr_upc;
    logic            o_valid;
    logic            i_ready;
    logic [4:0]      o_rd;
    logic            o_rd_wen;
    logic [31:0]     o_rd_data;
    logic [31:0]     o_npc;
    logic            o_redirect;

    always #5 clk = ~clk;

    csr_exec_unit #(.XLEN(XLEN), .ECALL_CAUSE(ECALL_CAUSE)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_funct3(i_funct3), .i_sys_t(i_sys_t), .i_csr_addr(i_csr_addr),
        .i_rs1_idx(i_rs1_idx), .i_rs1_data(i_rs1_data), .i_rd(i_rd),
        .o_csr_valid(o_csr_valid), .o_csr_wen(o_csr_wen), .o_csr_t(o_csr_t), .o_csr(o_csr),
        .o_csr_pc(o_csr_pc), .o_csr_wdata(o_csr_wdata), .o_csr_mcause(o_csr_mcause),
        .i_csr_rdata(i_csr_rdata), .i_csr_upc(i_csr_upc),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_rd_data(o_rd_data), .o_npc(o_npc),
        .o_redirect(o_redirect)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [1:0]  st;
        logic [11:0] csr;
        logic [4:0]  rs1;
        logic [31:0] rs1d;
        logic [4:0]  rd;
    } instr_t;

    typedef enum int {KCsr, KEcall, KMret, KIllegal} kind_t;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: where the one in-flight instruction is in its 3-cycle life.
    int     phase = 0;   // 0 waiting for accept, 1 CSR access cycle, 2 result offered
    instr_t m_ins;
    logic   m_rd_wen, m_redirect;
    logic [31:0] m_rd_data, m_npc;
    bit     accepted, done;
    int     wr_edges = 0;

    // Values the DUT showed, kept for the hand-computed literal checks.
    logic        obs_wen, obs_rd_wen, obs_redirect;
    logic [2:0]  obs_t;
    logic [31:0] obs_wdata, obs_csr_pc, obs_mcause, obs_rd_data, obs_npc;

    always @(posedge clk) if (o_csr_wen === 1'b1) wr_edges++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic kind_t kind_of(input instr_t x);
        if (x.f3 == 3'b100) return KIllegal;
        if (x.f3 != 3'b000) return KCsr;
        if (x.st == 2'b00) return KEcall;
        if (x.st == 2'b01) return KMret;
        return KIllegal;
    endfunction

    function automatic logic exp_csr_wen(input instr_t x);
        case (kind_of(x))
            KEcall: return 1'b1;
            KCsr:   return (x.f3 == 3'b001 || x.f3 == 3'b101) ? 1'b1 : (x.rs1 != 5'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input instr_t x, input logic [31:0] old);
        logic [31:0] src;
        src = (x.f3 >= 3'b101) ? 32'(x.rs1) : x.rs1d;
        case (x.f3)
            3'b001, 3'b101: return src;
            3'b010, 3'b110: return old | src;
            default:        return old & ~src;
        endcase
    endfunction

    task automatic drive_ins(input instr_t x);
        i_pc = x.pc; i_funct3 = x.f3; i_sys_t = x.st; i_csr_addr = x.csr;
        i_rs1_idx = x.rs1; i_rs1_data = x.rs1d; i_rd = x.rd;
    endtask

    task automatic check_and_advance();
        kind_t k;
        logic [2:0] et;
        chk("o_ready", 32'(o_ready), 32'(phase == 0));
        chk("o_valid", 32'(o_valid), 32'(phase == 2));
        chk("o_csr_valid", 32'(o_csr_valid), 32'(phase == 1));
        if (phase != 1) begin
            chk("csr_wen_quiet", 32'(o_csr_wen), 32'h0);
            chk("csr_t_quiet", 32'(o_csr_t), 32'h1);
        end else begin
            k  = kind_of(m_ins);
            et = (k == KEcall) ? 3'b011 : (k == KMret) ? 3'b000 : 3'b001;
            chk("csr_addr", 32'(o_csr), 32'(m_ins.csr));
            chk("csr_t", 32'(o_csr_t), 32'(et));
            chk("csr_wen", 32'(o_csr_wen), 32'(exp_csr_wen(m_ins)));
            if (k == KCsr && exp_csr_wen(m_ins))
                chk("csr_wdata", o_csr_wdata, exp_wdata(m_ins, i_csr_rdata));
            if (k == KEcall) begin
                chk("csr_pc", o_csr_pc, m_ins.pc);
                chk("csr_mcause", o_csr_mcause, 32'(ECALL_CAUSE));
            end
            m_rd_wen   = (k == KCsr) && (m_ins.rd != 5'd0);
            m_rd_data  = i_csr_rdata;
            m_redirect = (k == KEcall) || (k == KMret);
            m_npc      = m_redirect ? i_csr_upc : m_ins.pc + 32'd4;
            obs_wen = o_csr_wen; obs_t = o_csr_t; obs_wdata = o_csr_wdata;
            obs_csr_pc = o_csr_pc; obs_mcause = o_csr_mcause;
        end
        if (phase == 2) begin
            chk("rd", 32'(o_rd), 32'(m_ins.rd));
            chk("rd_wen", 32'(o_rd_wen), 32'(m_rd_wen));
            if (kind_of(m_ins) == KCsr) chk("rd_data", o_rd_data, m_rd_data);
            chk("npc", o_npc, m_npc);
            chk("redirect", 32'(o_redirect), 32'(m_redirect));
            obs_rd_wen = o_rd_wen; obs_rd_data = o_rd_data;
            obs_npc = o_npc; obs_redirect = o_redirect;
        end
        // What the coming clock edge does.
        if (phase == 0 && i_valid) begin
            m_ins = {i_pc, i_funct3, i_sys_t, i_csr_addr, i_rs1_idx, i_rs1_data, i_rd};
            phase = 1; accepted = 1'b1;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2 && i_ready) begin
            phase = 0; done = 1'b1;
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 ns later.
    task automatic cycle();
        accepted = 1'b0; done = 1'b0;
        #1;
        check_and_advance();
        @(negedge clk);
    endtask

    task automatic run_one(input instr_t x, input logic [31:0] rdata, input logic [31:0] upc);
        int guard = 0;
        bit fin = 1'b0;
        drive_ins(x); i_csr_rdata = rdata; i_csr_upc = upc; i_valid = 1'b1; i_ready = 1'b1;
        while (!fin && guard < 20) begin
            cycle();
            if (accepted) i_valid = 1'b0;
            fin = done;
            guard++;
        end
        chk("txn_timeout", 32'(fin), 32'h1);
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [2:0] f3,
                                  input logic [1:0] st, input logic [11:0] csr,
                                  input logic [4:0] rs1, input logic [31:0] rs1d,
                                  input logic [4:0] rd);
        return {pc, f3, st, csr, rs1, rs1d, rd};
    endfunction

    function automatic instr_t rand_ins();
        instr_t x;
        x.pc   = {$urandom(), 2'b00} ;
        x.f3   = 3'($urandom_range(0, 7));
        x.st   = 2'($urandom_range(0, 3));
        x.csr  = 12'($urandom());
        x.rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
        x.rs1d = $urandom();
        x.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
        return x;
    endfunction

    initial begin
        instr_t x;
        bit pending;
        int w0;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        drive_ins('0); i_csr_rdata = '0; i_csr_upc = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_csr_valid", 32'(o_csr_valid), 32'h0);
        chk("rst_csr_wen", 32'(o_csr_wen), 32'h0);
        chk("rst_rd_wen", 32'(o_rd_wen), 32'h0);
        chk("rst_redirect", 32'(o_redirect), 32'h0);
        chk("rst_rd_data", o_rd_data, 32'h0);
        chk("rst_npc", o_npc, 32'h0);
        chk("rst_rd", 32'(o_rd), 32'h0);
        chk("rst_csr_wdata", o_csr_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // CSRRW mstatus
        run_one(mk(32'h1000, 3'b001, 2'b00, 12'h300, 5'd5, 32'h1888, 5'd3), 32'h0, 32'hDEADBEEF);
        chk("lit_rw_wen", 32'(obs_wen), 32'h1);
        chk("lit_rw_wdata", obs_wdata, 32'h1888);
        chk("lit_rw_rd_wen", 32'(obs_rd_wen), 32'h1);
        chk("lit_rw_rd_data", obs_rd_data, 32'h0);
        chk("lit_rw_npc", obs_npc, 32'h1004);
        // CSRRS with x0 source: read-only
        run_one(mk(32'h1004, 3'b010, 2'b00, 12'h341, 5'd0, 32'hFFFF, 5'd4), 32'h80000010, 32'h0);
        chk("lit_rs0_wen", 32'(obs_wen), 32'h0);
        chk("lit_rs0_rd_data", obs_rd_data, 32'h80000010);
        // CSRRC
        run_one(mk(32'h1008, 3'b011, 2'b00, 12'h341, 5'd6, 32'h10, 5'd4), 32'h80000010, 32'h0);
        chk("lit_rc_wdata", obs_wdata, 32'h80000000);
        // CSRRSI zimm=5
        run_one(mk(32'h100C, 3'b110, 2'b00, 12'h305, 5'd5, 32'h0, 5'd2), 32'hA, 32'h0);
        chk("lit_rsi_wdata", obs_wdata, 32'hF);
        // CSRRWI rd=0
        run_one(mk(32'h1010, 3'b101, 2'b00, 12'h305, 5'd7, 32'h0, 5'd0), 32'h55, 32'h0);
        chk("lit_rwi_wen", 32'(obs_wen), 32'h1);
        chk("lit_rwi_rd_wen", 32'(obs_rd_wen), 32'h0);
        // ECALL
        run_one(mk(32'h80000100, 3'b000, 2'b00, 12'h0, 5'd0, 32'h0, 5'd5), 32'h1, 32'h80000400);
        chk("lit_ecall_t", 32'(obs_t), 32'h3);
        chk("lit_ecall_pc", obs_csr_pc, 32'h80000100);
        chk("lit_ecall_mcause", obs_mcause, 32'd11);
        chk("lit_ecall_npc", obs_npc, 32'h80000400);
        chk("lit_ecall_redirect", 32'(obs_redirect), 32'h1);
        chk("lit_ecall_rd_wen", 32'(obs_rd_wen), 32'h0);
        // MRET
        run_one(mk(32'h3000, 3'b000, 2'b01, 12'h302, 5'd0, 32'h0, 5'd1), 32'h0, 32'h80000200);
        chk("lit_mret_t", 32'(obs_t), 32'h0);
        chk("lit_mret_wen", 32'(obs_wen), 32'h0);
        chk("lit_mret_npc", obs_npc, 32'h80000200);
        // Illegal funct3=100 and SYSTEM sys_t=1x
        run_one(mk(32'h2000, 3'b100, 2'b00, 12'h300, 5'd3, 32'h7, 5'd9), 32'h9, 32'h4444);
        chk("lit_ill_wen", 32'(obs_wen), 32'h0);
        chk("lit_ill_npc", obs_npc, 32'h2004);
        chk("lit_ill_redirect", 32'(obs_redirect), 32'h0);
        run_one(mk(32'h2004, 3'b000, 2'b11, 12'h300, 5'd3, 32'h7, 5'd9), 32'h9, 32'h4444);
        chk("lit_ill_sys_t", 32'(obs_t), 32'h1);
        // PC wrap
        run_one(mk(32'hFFFFFFFC, 3'b001, 2'b00, 12'h340, 5'd1, 32'h1, 5'd1), 32'h0, 32'h0);
        chk("lit_wrap_npc", obs_npc, 32'h0);

        // Backpressure: 5 stalled cycles in WAIT with another instruction offered.
        drive_ins(mk(32'h4000, 3'b010, 2'b00, 12'h300, 5'd2, 32'h3, 5'd8));
        i_csr_rdata = 32'h1234; i_csr_upc = 32'h0; i_valid = 1'b1; i_ready = 1'b0;
        cycle();
        drive_ins(mk(32'h5000, 3'b001, 2'b00, 12'h301, 5'd2, 32'h3, 5'd8));
        cycle();
        w0 = wr_edges;
        for (int i = 0; i < 5; i++) begin
            i_csr_rdata = $urandom(); i_csr_upc = $urandom();
            cycle();
        end
        chk("bp_no_write", 32'(wr_edges), 32'(w0));
        chk("bp_rd_data", o_rd_data, 32'h1234);
        i_ready = 1'b1; i_valid = 1'b0;
        cycle();
        cycle();

        // Reset asserted during EXEC: no write edge, unit comes back idle.
        drive_ins(mk(32'h6000, 3'b001, 2'b00, 12'h300, 5'd4, 32'hAA, 5'd1));
        i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        w0 = wr_edges;
        rst_n = 1'b0;
        #1;
        chk("rexec_csr_valid", 32'(o_csr_valid), 32'h0);
        chk("rexec_csr_wen", 32'(o_csr_wen), 32'h0);
        phase = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rexec_no_write", 32'(wr_edges), 32'(w0));
        chk("rexec_valid", 32'(o_valid), 32'h0);
        chk("rexec_ready", 32'(o_ready), 32'h1);

        // Randomized traffic against the model.
        pending = 1'b0;
        x = rand_ins();
        for (int n = 0; n < 600; n++) begin
            if (!pending) begin x = rand_ins(); pending = 1'b1; end
            drive_ins(x);
            i_valid     = ($urandom_range(0, 3) != 0);
            i_ready     = ($urandom_range(0, 2) != 0);
            i_csr_rdata = $urandom();
            i_csr_upc   = $urandom();
            cycle();
            if (accepted) pending = 1'b0;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
